// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request feeding a two-entry queue toward if_id.
// Optional FETCH_QUEUE_BYPASS_EN forwards an ack straight to out_* when the queue is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetchState_e;

    localparam logic [1:0] QD = 2'(QDEPTH);

    fetchState_e state, stateNext;
    logic [31:0] fetchPc, fetchPcNext;
    logic [31:0] reqAddr;
    logic        reqLoad;
    logic        runEn;
    logic        ackData;
    logic        bypassHit;
    logic        pop;
    logic [1:0]  count, countNext;
    logic [31:0] pcQ0, pcQ1, instQ0, instQ1;
    logic [31:0] pcQ0Next, pcQ1Next, instQ0Next, instQ1Next;

    assign dbgState = state;

    // Request side: imem_req rises in the IDLE cycle that finds room and is then held, with
    // the same address, until the memory acks; a transfer completes on imem_ack alone.
    // Output side: an entry leaves the queue on any cycle with out_valid & out_ready.
    always_comb begin
        stateNext   = state;
        fetchPcNext = fetchPc;
        reqLoad     = 1'b0;
        ackData     = 1'b0;
        imem_req    = 1'b0;
        imem_addr   = reqAddr;
        case (state)
            IDLE: begin
                if (runEn && (count < QD)) begin
                    imem_req  = 1'b1;
                    imem_addr = fetchPc;
                    reqLoad   = 1'b1;
                    stateNext = redirect ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (!redirect) begin
                        ackData     = 1'b1;
                        fetchPcNext = fetchPc + 32'd4;
                    end
                    stateNext = IDLE;
                end else if (redirect) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (redirect) begin
            fetchPcNext = redirect_pc & 32'hFFFF_FFFC;
        end
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypassHit = ackData && (count == 2'd0);
    assign out_valid = (count != 2'd0) || bypassHit;
    assign out_pc    = bypassHit ? reqAddr    : pcQ0;
    assign out_inst  = bypassHit ? imem_rdata : instQ0;
`else
    assign bypassHit = 1'b0;
    assign out_valid = (count != 2'd0);
    assign out_pc    = pcQ0;
    assign out_inst  = instQ0;
`endif

    assign pop = (count != 2'd0) && out_ready;

    // Slot 0 is always the head; popping the last entry leaves its contents in place so
    // out_pc/out_inst keep showing the most recent instruction while out_valid is low.
    always_comb begin
        countNext  = count;
        pcQ0Next   = pcQ0;
        pcQ1Next   = pcQ1;
        instQ0Next = instQ0;
        instQ1Next = instQ1;
        if (redirect) begin
            countNext = 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (ackData) begin
                        pcQ0Next   = reqAddr;
                        instQ0Next = imem_rdata;
                        countNext  = (bypassHit && out_ready) ? 2'd0 : 2'd1;
                    end
                end
                2'd1: begin
                    if (ackData && pop) begin
                        pcQ0Next   = reqAddr;
                        instQ0Next = imem_rdata;
                    end else if (pop) begin
                        countNext = 2'd0;
                    end else if (ackData) begin
                        pcQ1Next   = reqAddr;
                        instQ1Next = imem_rdata;
                        countNext  = 2'd2;
                    end
                end
                default: begin
                    if (pop) begin
                        pcQ0Next   = pcQ1;
                        instQ0Next = instQ1;
                        if (ackData) begin
                            pcQ1Next   = reqAddr;
                            instQ1Next = imem_rdata;
                        end else begin
                            countNext = 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
            reqAddr <= RESET_PC;
            runEn   <= 1'b0;
            count   <= 2'd0;
            pcQ0    <= 32'd0;
            pcQ1    <= 32'd0;
            instQ0  <= 32'd0;
            instQ1  <= 32'd0;
        end else begin
            state   <= stateNext;
            fetchPc <= fetchPcNext;
            runEn   <= 1'b1;
            if (reqLoad) begin
                reqAddr <= fetchPc;
            end
            count   <= countNext;
            pcQ0    <= pcQ0Next;
            pcQ1    <= pcQ1Next;
            instQ0  <= instQ0Next;
            instQ1  <= instQ1Next;
        end
    end

endmodule
